// File: rtl/yu_ctrl_pkg.sv
// Shared control encodings for the Yu Core: opcodes, main FSM states and datapath mux selects.
package yu_ctrl_pkg;

    localparam logic [6:0] I_TYPE_INSTR = 7'b0000011;
    localparam logic [6:0] S_TYPE_INSTR = 7'b0100011;
    localparam logic [6:0] R_TYPE_INSTR = 7'b0110011;
    localparam logic [6:0] B_TYPE_INSTR = 7'b1100011;
    localparam logic [6:0] IALU_INSTR   = 7'b0010011;
    localparam logic [6:0] J_TYPE_INSTR = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        ILLEGAL
    } state_e;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Purely combinational opcode-to-immediate-format mapping, shared with the pipelined core.
module imm_src_decoder
    import yu_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [1:0] immSrc_o
);

    always_comb begin
        immSrc_o = IMM_I;
        case (opcode_i)
            I_TYPE_INSTR: immSrc_o = IMM_I;
            S_TYPE_INSTR: immSrc_o = IMM_S;
            B_TYPE_INSTR: immSrc_o = IMM_B;
            J_TYPE_INSTR: immSrc_o = IMM_J;
            default:      immSrc_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multi_cycle_main_fsm.sv
// Main multi-cycle control FSM: steps each instruction through fetch/decode/execute/memory/writeback
// and drives the ALU, register-file and unified-memory strobes.
module multi_cycle_main_fsm
    import yu_ctrl_pkg::*;
#(
    parameter bit SUPPORT_JAL     = 1'b1,
    parameter bit SUPPORT_IALU    = 1'b1,
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [6:0] opcode,
    input  logic       memReady,
    output logic       pcUpdate,
    output logic       branch,
    output logic       irWrite,
    output logic       regWrite,
    output logic       memWrite,
    output logic       adrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] resultSrc,
    output logic [1:0] ALUOpcode,
    output logic [1:0] immSrc,
    output logic       instrDone,
    output logic       illegalInstr
);

    state_e state_q, state_d;
    logic   isStore_q, isStore_d;
    logic   ready;
    logic   pcUpdateRaw, branchRaw, irWriteRaw, regWriteRaw, memWriteRaw;
    logic   instrDoneRaw, illegalRaw;

    assign ready = MEM_HANDSHAKE ? memReady : 1'b1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= FETCH;
            isStore_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            isStore_q <= isStore_d;
        end
    end

    // Load/store choice is latched at DECODE so later opcode changes cannot redirect MEMADR.
    always_comb begin
        state_d      = state_q;
        isStore_d    = isStore_q;
        pcUpdateRaw  = 1'b0;
        branchRaw    = 1'b0;
        irWriteRaw   = 1'b0;
        regWriteRaw  = 1'b0;
        memWriteRaw  = 1'b0;
        instrDoneRaw = 1'b0;
        illegalRaw   = 1'b0;
        adrSrc       = 1'b0;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        resultSrc    = RES_ALUOUT;
        ALUOpcode    = ALUOP_ADD;

        case (state_q)
            FETCH: begin
                ALUSrcB     = SRCB_FOUR;
                resultSrc   = RES_ALURESULT;
                irWriteRaw  = ready;
                pcUpdateRaw = ready;
                if (ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                isStore_d = (opcode == S_TYPE_INSTR);
                case (opcode)
                    I_TYPE_INSTR, S_TYPE_INSTR: state_d = MEMADR;
                    R_TYPE_INSTR:               state_d = EXECR;
                    IALU_INSTR:                 state_d = SUPPORT_IALU ? EXECI : ILLEGAL;
                    B_TYPE_INSTR:               state_d = BEQ;
                    J_TYPE_INSTR:               state_d = SUPPORT_JAL ? JAL : ILLEGAL;
                    default:                    state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = isStore_q ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adrSrc = 1'b1;
                if (ready) state_d = MEMWB;
            end
            MEMWB: begin
                resultSrc    = RES_MEMDATA;
                regWriteRaw  = 1'b1;
                instrDoneRaw = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                adrSrc       = 1'b1;
                memWriteRaw  = 1'b1;
                instrDoneRaw = ready;
                if (ready) state_d = FETCH;
            end
            EXECR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUOpcode = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            EXECI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ALUOpcode = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                regWriteRaw  = 1'b1;
                instrDoneRaw = 1'b1;
                state_d      = FETCH;
            end
            BEQ: begin
                ALUSrcA      = SRCA_RS1;
                ALUSrcB      = SRCB_RS2;
                ALUOpcode    = ALUOP_SUB;
                branchRaw    = 1'b1;
                instrDoneRaw = 1'b1;
                state_d      = FETCH;
            end
            JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                pcUpdateRaw = 1'b1;
                state_d     = ALUWB;
            end
            ILLEGAL: begin
                illegalRaw = 1'b1;
                if (!TRAP_ON_ILLEGAL) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are forced low for the whole time reset is held, even though FETCH looks at memReady.
    assign pcUpdate     = pcUpdateRaw  & rstN;
    assign branch       = branchRaw    & rstN;
    assign irWrite      = irWriteRaw   & rstN;
    assign regWrite     = regWriteRaw  & rstN;
    assign memWrite     = memWriteRaw  & rstN;
    assign instrDone    = instrDoneRaw & rstN;
    assign illegalInstr = illegalRaw   & rstN;

    imm_src_decoder uImmSrcDecoder (
        .opcode_i (opcode),
        .immSrc_o (immSrc)
    );

endmodule

// File: tb/tb_multi_cycle_main_fsm.sv
// Self-checking bench: two DUT configurations share one directed stimulus and are compared
// every cycle against an instruction-step model, plus literal latency/strobe-count expectations.
module tb_multi_cycle_main_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [3:0] C_NONE  = 4'd0;
    localparam logic [3:0] C_LOAD  = 4'd1;
    localparam logic [3:0] C_STORE = 4'd2;
    localparam logic [3:0] C_R     = 4'd3;
    localparam logic [3:0] C_I     = 4'd4;
    localparam logic [3:0] C_BR    = 4'd5;
    localparam logic [3:0] C_JAL   = 4'd6;
    localparam logic [3:0] C_BAD   = 4'd7;

    typedef struct packed {
        logic       pcUpdate;
        logic       branch;
        logic       irWrite;
        logic       regWrite;
        logic       memWrite;
        logic       adrSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic [1:0] aluOp;
        logic [1:0] immSrc;
        logic       instrDone;
        logic       illegalInstr;
    } outs_t;

    logic       clk;
    logic       rstN;
    logic [6:0] opcode;
    logic       memReady;

    logic       aPc, aBr, aIr, aReg, aMem, aAdr, aDone, aIll;
    logic [1:0] aSrcA, aSrcB, aRes, aAlu, aImm;
    logic       bPc, bBr, bIr, bReg, bMem, bAdr, bDone, bIll;
    logic [1:0] bSrcA, bSrcB, bRes, bAlu, bImm;

    logic [7:0] posA, posB;

    int checks = 0;
    int failures = 0;
    int sinceA = 0, lastLatA = 0;
    int regWrA = 0, memWrA = 0, pcUpdA = 0, irWrA = 0, illA = 0;
    int illCycB = 0, illRiseB = 0;
    bit prevIllB = 1'b0;

    multi_cycle_main_fsm #(
        .SUPPORT_JAL(1'b1), .SUPPORT_IALU(1'b1), .MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)
    ) dutA (
        .clk(clk), .rstN(rstN), .opcode(opcode), .memReady(memReady),
        .pcUpdate(aPc), .branch(aBr), .irWrite(aIr), .regWrite(aReg), .memWrite(aMem),
        .adrSrc(aAdr), .ALUSrcA(aSrcA), .ALUSrcB(aSrcB), .resultSrc(aRes),
        .ALUOpcode(aAlu), .immSrc(aImm), .instrDone(aDone), .illegalInstr(aIll)
    );

    multi_cycle_main_fsm #(
        .SUPPORT_JAL(1'b0), .SUPPORT_IALU(1'b0), .MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0)
    ) dutB (
        .clk(clk), .rstN(rstN), .opcode(opcode), .memReady(memReady),
        .pcUpdate(bPc), .branch(bBr), .irWrite(bIr), .regWrite(bReg), .memWrite(bMem),
        .adrSrc(bAdr), .ALUSrcA(bSrcA), .ALUSrcB(bSrcB), .resultSrc(bRes),
        .ALUOpcode(bAlu), .immSrc(bImm), .instrDone(bDone), .illegalInstr(bIll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] immOf(input logic [6:0] op);
        case (op)
            OP_SW:   return 2'd1;
            OP_BEQ:  return 2'd2;
            OP_JAL:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] classify(input logic [6:0] op, input bit jal, input bit ialu);
        case (op)
            OP_LW:   return C_LOAD;
            OP_SW:   return C_STORE;
            OP_R:    return C_R;
            OP_I:    return ialu ? C_I : C_BAD;
            OP_BEQ:  return C_BR;
            OP_JAL:  return jal ? C_JAL : C_BAD;
            default: return C_BAD;
        endcase
    endfunction

    // Step 0 is fetch, step 1 decode; each class then has its own number of steps.
    function automatic logic [3:0] lastStep(input logic [3:0] cls);
        case (cls)
            C_LOAD:      return 4'd4;
            C_BR, C_BAD: return 4'd2;
            default:     return 4'd3;
        endcase
    endfunction

    function automatic bit waitsOnMem(input logic [3:0] cls, input logic [3:0] step);
        return (step == 4'd0) || ((cls == C_LOAD || cls == C_STORE) && step == 4'd3);
    endfunction

    function automatic logic [7:0] nextPos(input logic [3:0] cls, input logic [3:0] step, input bit rdy,
                                           input logic [6:0] op, input bit jal, input bit ialu, input bit trap);
        if (waitsOnMem(cls, step) && !rdy) return {cls, step};
        if (step == 4'd0) return {C_NONE, 4'd1};
        if (step == 4'd1) return {classify(op, jal, ialu), 4'd2};
        if (step == lastStep(cls)) return (cls == C_BAD && trap) ? {cls, step} : {C_NONE, 4'd0};
        return {cls, step + 4'd1};
    endfunction

    function automatic outs_t expOut(input bit live, input logic [3:0] cls, input logic [3:0] step,
                                     input bit rdy, input logic [6:0] op);
        outs_t o;
        o = '0;
        o.immSrc = immOf(op);
        if (!live || step == 4'd0) begin
            o.aluSrcB   = 2'd2;
            o.resultSrc = 2'd2;
            o.irWrite   = live & rdy;
            o.pcUpdate  = live & rdy;
            return o;
        end
        if (step == 4'd1) begin
            o.aluSrcA = 2'd1;
            o.aluSrcB = 2'd1;
            return o;
        end
        case (cls)
            C_LOAD, C_STORE: begin
                if (step == 4'd2) begin
                    o.aluSrcA = 2'd2;
                    o.aluSrcB = 2'd1;
                end else if (step == 4'd3) begin
                    o.adrSrc    = 1'b1;
                    o.memWrite  = (cls == C_STORE);
                    o.instrDone = (cls == C_STORE) && rdy;
                end else begin
                    o.resultSrc = 2'd1;
                    o.regWrite  = 1'b1;
                    o.instrDone = 1'b1;
                end
            end
            C_R, C_I, C_JAL: begin
                if (step == 4'd3) begin
                    o.regWrite  = 1'b1;
                    o.instrDone = 1'b1;
                end else if (cls == C_JAL) begin
                    o.aluSrcA  = 2'd1;
                    o.aluSrcB  = 2'd2;
                    o.pcUpdate = 1'b1;
                end else begin
                    o.aluSrcA = 2'd2;
                    o.aluSrcB = (cls == C_I) ? 2'd1 : 2'd0;
                    o.aluOp   = 2'd2;
                end
            end
            C_BR: begin
                o.aluSrcA   = 2'd2;
                o.aluOp     = 2'd1;
                o.branch    = 1'b1;
                o.instrDone = 1'b1;
            end
            default: o.illegalInstr = 1'b1;
        endcase
        return o;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            posA <= 8'h00;
            posB <= 8'h00;
        end else begin
            posA <= nextPos(posA[7:4], posA[3:0], memReady, opcode, 1'b1, 1'b1, 1'b1);
            posB <= nextPos(posB[7:4], posB[3:0], 1'b1, opcode, 1'b0, 1'b0, 1'b0);
        end
    end

    task automatic compareOutputs();
        outs_t eA, eB, gA, gB;
        eA = expOut(rstN, posA[7:4], posA[3:0], memReady, opcode);
        eB = expOut(rstN, posB[7:4], posB[3:0], 1'b1, opcode);
        gA = {aPc, aBr, aIr, aReg, aMem, aAdr, aSrcA, aSrcB, aRes, aAlu, aImm, aDone, aIll};
        gB = {bPc, bBr, bIr, bReg, bMem, bAdr, bSrcA, bSrcB, bRes, bAlu, bImm, bDone, bIll};
        checks++;
        if (gA !== eA) begin
            failures++;
            $display("[TB] FAIL cycleA t=%0t actual=%b required=%b", $time, gA, eA);
        end
        checks++;
        if (gB !== eB) begin
            failures++;
            $display("[TB] FAIL cycleB t=%0t actual=%b required=%b", $time, gB, eB);
        end
    endtask

    task automatic tally();
        if (!rstN) begin
            sinceA = 0;
        end else begin
            sinceA++;
            if (aReg) regWrA++;
            if (aMem) memWrA++;
            if (aPc)  pcUpdA++;
            if (aIr)  irWrA++;
            if (aIll) illA++;
            if (aDone) begin
                lastLatA = sinceA;
                sinceA   = 0;
            end
        end
        if (bIll) illCycB++;
        if (bIll && !prevIllB) illRiseB++;
        prevIllB = bIll;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic rdy);
        opcode   = op;
        memReady = rdy;
        @(negedge clk);
        compareOutputs();
        tally();
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input logic [6:0] op, input int n);
        for (int i = 0; i < n; i++) applyStimulus(op, 1'b1);
    endtask

    initial begin
        int r0, m0, p0, i0, w0, bc0, br0;
        rstN     = 1'b0;
        opcode   = OP_LW;
        memReady = 1'b1;
        runOp(OP_LW, 2);
        checkOutput("rstIrWrite", int'(aIr), 0);
        checkOutput("rstPcUpdate", int'(aPc), 0);
        rstN = 1'b1;

        r0 = regWrA;
        runOp(OP_LW, 5);
        checkOutput("lwLatency", lastLatA, 5);
        checkOutput("lwRegWrites", regWrA - r0, 1);

        r0 = regWrA;
        m0 = memWrA;
        runOp(OP_SW, 3);
        for (int i = 0; i < 3; i++) applyStimulus(OP_SW, 1'b0);
        applyStimulus(OP_SW, 1'b1);
        checkOutput("swLatency", lastLatA, 7);
        checkOutput("swMemWrites", memWrA - m0, 4);
        checkOutput("swRegWrites", regWrA - r0, 0);

        runOp(OP_BEQ, 3);
        checkOutput("beqLatency", lastLatA, 3);

        p0  = pcUpdA;
        bc0 = illCycB;
        br0 = illRiseB;
        runOp(OP_JAL, 4);
        checkOutput("jalLatency", lastLatA, 4);
        checkOutput("jalPcUpdates", pcUpdA - p0, 2);
        runOp(OP_JAL, 4);
        checkOutput("bJalTrapsIllegal", int'(illRiseB - br0 > 0), 1);
        checkOutput("bIllegalIsPulse", illCycB - bc0, illRiseB - br0);

        runOp(OP_I, 4);
        checkOutput("ialuLatency", lastLatA, 4);

        applyStimulus(OP_R, 1'b0);
        runOp(OP_R, 4);
        checkOutput("rFetchWaitLatency", lastLatA, 5);

        runOp(OP_LW, 3);
        applyStimulus(OP_LW, 1'b0);
        applyStimulus(OP_LW, 1'b0);
        runOp(OP_LW, 2);
        checkOutput("lwReadWaitLatency", lastLatA, 7);

        i0 = illA;
        w0 = irWrA;
        runOp(OP_BAD, 22);
        checkOutput("trapIllegalCycles", illA - i0, 20);
        checkOutput("trapNoRefetch", irWrA - w0, 1);

        rstN = 1'b0;
        runOp(OP_SW, 2);
        rstN = 1'b1;
        runOp(OP_SW, 3);
        opcode   = OP_SW;
        memReady = 1'b0;
        #2;
        checkOutput("swMemWriteHeld", int'(aMem), 1);
        rstN = 1'b0;
        #1;
        checkOutput("swMemWriteAsyncDrop", int'(aMem), 0);
        compareOutputs();
        applyStimulus(OP_SW, 1'b0);
        opcode   = OP_LW;
        memReady = 1'b1;
        rstN     = 1'b1;
        #1;
        checkOutput("fetchAfterReset", int'(aIr), 1);
        runOp(OP_LW, 5);
        checkOutput("lwAfterResetLatency", lastLatA, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_main_fsm.md
# multi_cycle_main_fsm

Main control state machine for the multi-cycle Yu Core. Sequences each instruction through fetch, decode, execute, memory and writeback steps from the 7-bit opcode. It drives the shared ALU, register-file and unified-memory control strobes cycle by cycle. It adds a memory ready handshake, optional JAL and I-type ALU support, illegal-opcode trapping, and a retired-instruction pulse.

## Interface
- SUPPORT_JAL, 1, enables the JAL path; 0 makes opcode 1101111 illegal.
- SUPPORT_IALU, 1, enables the I-type ALU path; 0 makes opcode 0010011 illegal.
- MEM_HANDSHAKE, 1, memory steps wait for memReady; 0 means memReady is ignored and treated as 1.
- TRAP_ON_ILLEGAL, 1, illegal opcode parks the FSM in ILLEGAL until reset; 0 gives a one-cycle pulse, then FETCH.
- clk, in, 1, the core clock; all state changes on its rising edge.
- rstN, in, 1, reset, asynchronous assert, active-low.
- opcode, in, 7, instr[6:0] from the instruction register, stable from DECODE until the instruction completes.
- memReady, in, 1, memory completes the access this cycle.
- pcUpdate, out, 1, PC register write enable.
- branch, out, 1, PC is written if ALU zero.
- irWrite, out, 1, instruction register write enable.
- regWrite, out, 1, register-file write enable.
- memWrite, out, 1, memory write request.
- adrSrc, out, 1, memory address select: 0 = PC, 1 = result.
- ALUSrcA, out, 2, ALU operand A select: 00 = PC, 01 = oldPC, 10 = rs1.
- ALUSrcB, out, 2, ALU operand B select: 00 = rs2, 01 = imm, 10 = constant 4.
- resultSrc, out, 2, result select: 00 = ALUOut, 01 = memData, 10 = ALU result.
- ALUOpcode, out, 2, ALU operation class: 00 = add, 01 = sub/compare, 10 = funct decode.
- immSrc, out, 2, immediate format select: 00 = I, 01 = S, 10 = B, 11 = J.
- instrDone, out, 1, one-cycle pulse in the last cycle of every legal instruction.
- illegalInstr, out, 1, illegal-opcode indication (sticky or pulse, per TRAP_ON_ILLEGAL).

## Operation
- The FSM is Moore: outputs decode from the state register only. The exceptions are immSrc (combinational from opcode) and the handshake gating listed in Timing.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL.
- FETCH: adrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOpcode 00, resultSrc 10. irWrite and pcUpdate are asserted only when memReady is 1.
  - Advances to DECODE when memReady is 1; otherwise holds.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOpcode 00 (computes the branch target). Next state by opcode:
  - 0000011 and 0100011 go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1100011 goes to BEQ.
  - 1101111 goes to JAL.
  - Any other opcode, or a disabled path, goes to ILLEGAL.
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOpcode 00. Goes to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adrSrc 1, resultSrc 00. Holds until memReady, then goes to MEMWB.
- MEMWB: resultSrc 01, regWrite 1, instrDone 1. Goes to FETCH.
- MEMWRITE: adrSrc 1, resultSrc 00, memWrite 1 held until memReady. instrDone is asserted in the memReady cycle; then goes to FETCH.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALUOpcode 10. Goes to ALUWB.
- EXECI: ALUSrcA 10, ALUSrcB 01, ALUOpcode 10. Goes to ALUWB.
- ALUWB: resultSrc 00, regWrite 1, instrDone 1. Goes to FETCH.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOpcode 01, resultSrc 00, branch 1, instrDone 1. Goes to FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOpcode 00, resultSrc 00, pcUpdate 1. Goes to ALUWB.
- ILLEGAL: illegalInstr 1, all write strobes 0.
  - TRAP_ON_ILLEGAL = 1: holds in ILLEGAL until reset.
  - TRAP_ON_ILLEGAL = 0: goes to FETCH.
- In any state, every output not listed for that state is 0.
- immSrc: 0000011 gives 00; 0100011 gives 01; 1100011 gives 10; 1101111 gives 11; any other opcode gives 00.

## Timing
- Reset (rstN low, asynchronous): state becomes FETCH. While rstN is low, every strobe is forced to 0 (pcUpdate, irWrite, regWrite, memWrite, branch, instrDone, illegalInstr). All mux selects take their FETCH values.
- After reset release, the first access is the FETCH in the first clk edge with memReady = 1.
- Latency with memReady always 1:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
  - Each memory step adds one cycle per memReady = 0 cycle.
- memReady is sampled in the same cycle. Write strobes stay constant while waiting. No strobe pulses twice for one access.
- Reset asserted mid-instruction aborts it immediately: no partial regWrite, memWrite strobes drop at once.
- Opcode changes outside DECODE are ignored, except by immSrc.

## Structure
- Package yu_ctrl_pkg holds:
  - opcode constants (I_TYPE_INSTR, S_TYPE_INSTR, R_TYPE_INSTR, B_TYPE_INSTR, IALU_INSTR, J_TYPE_INSTR);
  - the state enum (4-bit);
  - ALUSrcA, ALUSrcB, resultSrc and ALUOpcode encodings.
- Sub-module imm_src_decoder: purely combinational opcode-to-immSrc mapping, reusable by the pipelined core.

## Test plan
- Reset then lw (0000011), memReady = 1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regWrite = 1 only in cycle 5, instrDone pulses in cycle 5.
- sw (0100011) with memReady held 0 for 3 cycles in MEMWRITE: memWrite is held 1 for 4 cycles, then FETCH. Total 7 cycles, regWrite never 1.
- beq (1100011): cycle 3 has branch 1, ALUOpcode 01, ALUSrcA 10, ALUSrcB 00. Total 3 cycles.
- jal (1101111) with SUPPORT_JAL = 1: pcUpdate in cycles 1 and 3, regWrite in cycle 4, immSrc 11. With SUPPORT_JAL = 0: goes to ILLEGAL.
- Opcode 1111111 with TRAP_ON_ILLEGAL = 1: illegalInstr stays 1 for 20 cycles and FETCH is never re-entered. With TRAP_ON_ILLEGAL = 0: one-cycle pulse, then FETCH.
- rstN dropped in MEMWRITE with memWrite = 1: memWrite goes to 0 asynchronously (before the next clk edge), and the state is FETCH on release.
